instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Instruction-fetch (IF) stage of the pipelined LEGv8 processor. Owns the program counter, drives the combinational instruction ROM address, and captures the returned word into the IF/ID pipeline register. Handles load-use stalls from ID and taken-branch redirects from later stages; can optionally redirect unconditional `B` directly in fetch.

## Interface
Parameters:
- `RESET_PC`, 64'd0, PC value loaded on reset.
- `IMEM_BYTES`, 1024, instruction ROM size in bytes; power of two, >4.

Ports:
- `clk`, in, 1, Clock; all state updates on posedge.
- `reset`, in, 1, Reset; synchronous, active-high.
- `stall`, in, 1, Hold PC and IF/ID (load-use hazard from ID).
- `branch_taken`, in, 1, Redirect request from a later stage.
- `branch_target`, in, 64, Byte address for the redirect.
- `imem_address`, out, 64, Address to the instruction ROM; equals current PC.
- `imem_instruction`, in, 32, ROM read data, combinational from `imem_address`.
- `if_id_pc`, out, 64, PC of the captured instruction.
- `if_id_instruction`, out, 32, Captured instruction; 32'h0 when invalid.
- `if_id_valid`, out, 1, IF/ID holds a real instruction.
- `if_id_predicted`, out, 1, Captured `B` was already redirected in fetch.
- `fetch_error`, out, 1, Sticky: misaligned target or PC out of ROM range.

## Operation
- State: `pc` (64b), IF/ID register (`pc`, `instruction`, `valid`, `predicted`), sticky `fetch_error`.
- `imem_address = pc` (combinational).
- Next-state priority, evaluated each posedge:
  1. `reset`: `pc <= RESET_PC`; IF/ID cleared (pc 0, instr 0, valid 0, predicted 0); `fetch_error <= 0`.
  2. `branch_taken` (ignores `stall`): `pc <= {branch_target[63:2],2'b00}`; IF/ID flushed to the bubble (valid 0, instr 0, predicted 0, pc 0). If `branch_target[1:0] != 0`, set `fetch_error`.
  3. `stall`: `pc` and the IF/ID register hold.
  4. Otherwise: IF/ID captures `{pc, imem_instruction, valid=1, predicted}`; `pc <= next_seq`.
- `next_seq = pc + 4` (64-bit, wraps modulo 2^64; no saturation).
- Range check: if `pc + 3 >= IMEM_BYTES` during a capture cycle, capture a bubble (valid 0, instr 0), set `fetch_error`, and still advance `pc`.
- `fetch_error` clears only on `reset`.
- Downstream must treat `if_id_valid=0` as a NOP and must not re-issue a redirect for an instruction with `if_id_predicted=1`.

## Timing
- Fetch latency 1 cycle: the word at `pc` appears on `if_id_*` after the posedge following presentation of `pc`.
- Throughput: one instruction per cycle when neither `stall` nor `branch_taken` is asserted.
- Redirect: a `branch_taken` asserted in cycle N puts `branch_target` on `imem_address` in N+1, and its instruction is valid in IF/ID in N+2. IF/ID is a bubble in N+1.
- `stall` held for K cycles freezes outputs for K cycles. Fetch resumes in the cycle after deassertion.
- `reset` deasserted at edge E: `imem_address = RESET_PC` immediately after E. The first valid IF/ID occurs at E+1.

## Configuration
- `FETCH_UNCOND_BRANCH_EN` defined: in a normal capture cycle (no reset, branch, or stall), if `imem_instruction[31:26] == 6'b000101`:
  - `pc <= pc + (sext(imm26) << 2)` instead of `pc + 4`.
  - The `B` itself is captured with `predicted=1`.
  - Saves the later-stage redirect bubble(s).
- Not defined: `if_id_predicted` is tied 0 and `B` resolves downstream like any other branch.

## Test plan
- Reset then free-run with ROM words at 0, 4, 8 → `if_id_pc` sequence 0, 4, 8 on consecutive cycles, `if_id_valid=1` from the first edge after reset, `fetch_error=0`.
- `stall` held 3 cycles while `pc=8` → `imem_address` stays 8 and IF/ID keeps pc 4 for 3 cycles; the next cycle captures pc 8.
- `branch_taken=1`, `branch_target=0x40`, asserted together with `stall=1` → next cycle `imem_address=0x40` with an IF/ID bubble (valid 0, instr 0); following cycle `if_id_pc=0x40`, valid 1.
- `branch_target=0x42` → `pc=0x40`, `fetch_error=1` and remains 1 until `reset`.
- With `IMEM_BYTES=1024`, run to `pc=0x3FC` then `0x400` → 0x3FC captured valid; at 0x400 a bubble is captured and `fetch_error=1`.
- With the macro defined, `B #+4` (word 32'h14000004) at pc 0x10 → next `imem_address=0x20`, with `if_id_predicted=1` on the `B`. Without the macro, next address is 0x14 and `predicted=0`.

Source files
------------

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - LEGv8 instruction-fetch stage: PC, ROM address, IF/ID register
//
// Optional feature macro: FETCH_UNCOND_BRANCH_EN (resolve unconditional B in fetch)
//
// Ports:
//   clk                in   clock, all state updates on posedge
//   reset              in   synchronous active-high reset
//   stall              in   hold PC and IF/ID (load-use hazard from ID)
//   branch_taken       in   redirect request from a later stage
//   branch_target      in   byte address of the redirect
//   imem_address       out  instruction ROM address (current PC)
//   imem_instruction   in   ROM read data, combinational from imem_address
//   if_id_pc           out  PC of the captured instruction
//   if_id_instruction  out  captured instruction, 0 when invalid
//   if_id_valid        out  IF/ID holds a real instruction
//   if_id_predicted    out  captured B was already redirected in fetch
//   fetch_error        out  sticky: misaligned target or PC outside the ROM

module instruction_fetch #(
   parameter logic [63:0] RESET_PC   = 64'd0,
   parameter int          IMEM_BYTES = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [63:0] branch_target,
   output logic [63:0] imem_address,
   input  logic [31:0] imem_instruction,
   output logic [63:0] if_id_pc,
   output logic [31:0] if_id_instruction,
   output logic        if_id_valid,
   output logic        if_id_predicted,
   output logic        fetch_error
);

   logic [63:0] pc;
   logic [63:0] next_seq;
   logic [63:0] capture_next_pc;
   logic        out_of_range;
   logic        is_uncond_b;

   assign imem_address = pc;
   assign next_seq     = pc + 64'd4;

   // 65-bit compare so a PC near the top of the address space cannot wrap
   // back into the ROM range when the last byte of the word is computed.
   assign out_of_range = ({1'b0, pc} + 65'd3) >= 65'(IMEM_BYTES);

`ifdef FETCH_UNCOND_BRANCH_EN
   logic [63:0] b_offset;

   // B: opcode 000101, imm26 is a signed word offset.
   assign is_uncond_b     = (imem_instruction[31:26] == 6'b000101);
   assign b_offset        = {{36{imem_instruction[25]}}, imem_instruction[25:0], 2'b00};
   assign capture_next_pc = is_uncond_b ? (pc + b_offset) : next_seq;
`else
   assign is_uncond_b     = 1'b0;
   assign capture_next_pc = next_seq;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         pc                <= RESET_PC;
         if_id_pc          <= 64'd0;
         if_id_instruction <= 32'h0;
         if_id_valid       <= 1'b0;
         if_id_predicted   <= 1'b0;
         fetch_error       <= 1'b0;
      end else if (branch_taken) begin
         // Redirect wins over stall: the stalled instruction is being squashed anyway.
         pc                <= {branch_target[63:2], 2'b00};
         if_id_pc          <= 64'd0;
         if_id_instruction <= 32'h0;
         if_id_valid       <= 1'b0;
         if_id_predicted   <= 1'b0;
         if (branch_target[1:0] != 2'b00) begin
            fetch_error <= 1'b1;
         end
      end else if (!stall) begin
         if (out_of_range) begin
            // ROM data is meaningless here; insert a bubble but keep walking.
            pc                <= next_seq;
            if_id_pc          <= 64'd0;
            if_id_instruction <= 32'h0;
            if_id_valid       <= 1'b0;
            if_id_predicted   <= 1'b0;
            fetch_error       <= 1'b1;
         end else begin
            pc                <= capture_next_pc;
            if_id_pc          <= pc;
            if_id_instruction <= imem_instruction;
            if_id_valid       <= 1'b1;
            if_id_predicted   <= is_uncond_b;
         end
      end
   end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - self-checking bench for instruction_fetch

module tb_instruction_fetch;

   localparam int IMEM_BYTES = 1024;

   logic        clk;
   logic        reset;
   logic        stall;
   logic        branch_taken;
   logic [63:0] branch_target;
   logic [63:0] imem_address;
   logic [31:0] imem_instruction;
   logic [63:0] if_id_pc;
   logic [31:0] if_id_instruction;
   logic        if_id_valid;
   logic        if_id_predicted;
   logic        fetch_error;

   int n_pass;
   int n_total;

   logic [31:0] rom [0:255];

   instruction_fetch #(
      .RESET_PC   (64'd0),
      .IMEM_BYTES (IMEM_BYTES)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .stall             (stall),
      .branch_taken      (branch_taken),
      .branch_target     (branch_target),
      .imem_address      (imem_address),
      .imem_instruction  (imem_instruction),
      .if_id_pc          (if_id_pc),
      .if_id_instruction (if_id_instruction),
      .if_id_valid       (if_id_valid),
      .if_id_predicted   (if_id_predicted),
      .fetch_error       (fetch_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] romword(input logic [63:0] a);
      if (a < 64'(IMEM_BYTES)) return rom[a[9:2]];
      return 32'hDEADBEEF;
   endfunction

   assign imem_instruction = romword(imem_address);

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
   endtask

   typedef struct {
      logic        rst;
      logic        stl;
      logic        br;
      logic [63:0] tgt;
      logic [63:0] e_addr;
      logic        e_valid;
      logic [63:0] e_pc;
      logic [31:0] e_instr;
      logic        e_pred;
      logic        e_err;
   } vec_t;

   vec_t vt [$];

   function automatic vec_t mk(input logic rst, input logic stl, input logic br,
                               input logic [63:0] tgt, input logic [63:0] e_addr,
                               input logic e_valid, input logic [63:0] e_pc,
                               input logic e_pred, input logic e_err);
      vec_t v;
      v.rst = rst; v.stl = stl; v.br = br; v.tgt = tgt;
      v.e_addr = e_addr; v.e_valid = e_valid; v.e_pc = e_pc;
      v.e_instr = e_valid ? romword(e_pc) : 32'h0;
      v.e_pred = e_pred; v.e_err = e_err;
      return v;
   endfunction

   // Reference model state
   logic [63:0] m_pc;
   logic        m_valid;
   logic [63:0] m_qpc;
   logic [31:0] m_instr;
   logic        m_pred;
   logic        m_err;

   task automatic model_step(input logic rst, input logic stl, input logic br, input logic [63:0] tgt);
      logic [31:0] w;
      if (rst) begin
         m_pc = 0; m_valid = 0; m_qpc = 0; m_instr = 0; m_pred = 0; m_err = 0;
      end else if (br) begin
         m_pc = tgt - (tgt % 4);
         m_valid = 0; m_qpc = 0; m_instr = 0; m_pred = 0;
         if (tgt % 4 != 0) m_err = 1;
      end else if (!stl) begin
         if (m_pc + 3 >= IMEM_BYTES) begin
            m_valid = 0; m_instr = 0; m_pred = 0; m_err = 1;
            m_pc = m_pc + 4;
         end else begin
            w = romword(m_pc);
            m_valid = 1; m_qpc = m_pc; m_instr = w; m_pred = 0;
`ifdef FETCH_UNCOND_BRANCH_EN
            if (w[31:26] == 6'b000101) begin
               m_pred = 1;
               m_pc = m_pc + 64'($signed(w[25:0])) * 4;
            end else begin
               m_pc = m_pc + 4;
            end
`else
            m_pc = m_pc + 4;
`endif
         end
      end
   endtask

   initial begin
      vec_t v;
      logic        r_rst, r_stl, r_br;
      logic [63:0] r_tgt;
      logic        b_pred;
      logic [63:0] b_next;

      n_pass  = 0;
      n_total = 0;
      for (int i = 0; i < 256; i++) rom[i] = 32'h8B000000 | 32'(i * 7);
      rom[4] = 32'h14000004; // B #+4 at 0x10

`ifdef FETCH_UNCOND_BRANCH_EN
      b_pred = 1'b1; b_next = 64'h20;
`else
      b_pred = 1'b0; b_next = 64'h14;
`endif

      //          rst stl br  tgt      addr    val pc      pred  err
      vt.push_back(mk(1, 0, 0, 0,       0,      0, 0,      0,    0));
      vt.push_back(mk(0, 0, 0, 0,       4,      1, 0,      0,    0));
      vt.push_back(mk(0, 0, 0, 0,       8,      1, 4,      0,    0));
      vt.push_back(mk(0, 1, 0, 0,       8,      1, 4,      0,    0));
      vt.push_back(mk(0, 1, 0, 0,       8,      1, 4,      0,    0));
      vt.push_back(mk(0, 1, 0, 0,       8,      1, 4,      0,    0));
      vt.push_back(mk(0, 0, 0, 0,       'hC,    1, 8,      0,    0));
      vt.push_back(mk(0, 0, 0, 0,       'h10,   1, 'hC,    0,    0));
      vt.push_back(mk(0, 0, 0, 0,       b_next, 1, 'h10,   b_pred, 0));
      vt.push_back(mk(0, 1, 1, 'h40,    'h40,   0, 0,      0,    0));
      vt.push_back(mk(0, 0, 0, 0,       'h44,   1, 'h40,   0,    0));
      vt.push_back(mk(0, 0, 1, 'h42,    'h40,   0, 0,      0,    1));
      vt.push_back(mk(0, 0, 0, 0,       'h44,   1, 'h40,   0,    1));
      vt.push_back(mk(0, 0, 1, 'h3F8,   'h3F8,  0, 0,      0,    1));
      vt.push_back(mk(1, 0, 0, 0,       0,      0, 0,      0,    0));
      vt.push_back(mk(0, 0, 1, 'h3F8,   'h3F8,  0, 0,      0,    0));
      vt.push_back(mk(0, 0, 0, 0,       'h3FC,  1, 'h3F8,  0,    0));
      vt.push_back(mk(0, 0, 0, 0,       'h400,  1, 'h3FC,  0,    0));
      vt.push_back(mk(0, 0, 0, 0,       'h404,  0, 0,      0,    1));
      vt.push_back(mk(0, 0, 0, 0,       'h408,  0, 0,      0,    1));
      vt.push_back(mk(1, 1, 1, 'h42,    0,      0, 0,      0,    0));

      reset = 1; stall = 0; branch_taken = 0; branch_target = 0;
      @(posedge clk); #1;

      foreach (vt[i]) begin
         v = vt[i];
         reset = v.rst; stall = v.stl; branch_taken = v.br; branch_target = v.tgt;
         @(posedge clk); #1;
         check($sformatf("vec%0d addr", i),  imem_address,      v.e_addr);
         check($sformatf("vec%0d valid", i), 64'(if_id_valid),  64'(v.e_valid));
         if (v.e_valid || v.rst || v.br)
            check($sformatf("vec%0d pc", i), if_id_pc,          v.e_pc);
         check($sformatf("vec%0d instr", i), 64'(if_id_instruction), 64'(v.e_instr));
         check($sformatf("vec%0d pred", i),  64'(if_id_predicted),   64'(v.e_pred));
         check($sformatf("vec%0d err", i),   64'(fetch_error),       64'(v.e_err));
      end

      // Randomized run against the reference model, starting from reset.
      reset = 1; stall = 0; branch_taken = 0;
      @(posedge clk); #1;
      model_step(1, 0, 0, 0);
      for (int c = 0; c < 2000; c++) begin
         r_rst = ($urandom_range(0, 99) < 2);
         r_stl = ($urandom_range(0, 99) < 20);
         r_br  = ($urandom_range(0, 99) < 12);
         r_tgt = 64'($urandom_range(0, 'h47F));
         if ($urandom_range(0, 3) != 0) r_tgt[1:0] = 2'b00;
         reset = r_rst; stall = r_stl; branch_taken = r_br; branch_target = r_tgt;
         @(posedge clk); #1;
         model_step(r_rst, r_stl, r_br, r_tgt);
         check("rnd addr",  imem_address,            m_pc);
         check("rnd valid", 64'(if_id_valid),        64'(m_valid));
         if (m_valid) check("rnd pc", if_id_pc,      m_qpc);
         check("rnd instr", 64'(if_id_instruction),  64'(m_instr));
         check("rnd pred",  64'(if_id_predicted),    64'(m_pred));
         check("rnd err",   64'(fetch_error),        64'(m_err));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
